// File: rtl/diabetes_pkg.sv
// Shared widths, feature indices, FSM states and model coefficients for the classifier.
package diabetes_pkg;

    localparam int unsigned FEAT_W    = 14;
    localparam int unsigned WEIGHT_W  = 16;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned N_FEAT    = 7;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned PROD_W    = WEIGHT_W + FEAT_W + 1;
    localparam int unsigned OUTCOME_W = 4;
    localparam int unsigned FEAT_MAX  = 9999;

    typedef enum logic [IDX_W-1:0] {
        PREGNANCIES    = 3'd0,
        GLUCOSE        = 3'd1,
        BLOOD_PRESSURE = 3'd2,
        SKIN_THICKNESS = 3'd3,
        INSULIN        = 3'd4,
        BMI            = 3'd5,
        AGE            = 3'd6
    } feature_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DECIDE
    } state_e;

    localparam logic signed [WEIGHT_W-1:0] W_PREGNANCIES    = WEIGHT_W'(32);
    localparam logic signed [WEIGHT_W-1:0] W_GLUCOSE        = WEIGHT_W'(9);
    localparam logic signed [WEIGHT_W-1:0] W_BLOOD_PRESSURE = WEIGHT_W'(-3);
    localparam logic signed [WEIGHT_W-1:0] W_SKIN_THICKNESS = WEIGHT_W'(0);
    localparam logic signed [WEIGHT_W-1:0] W_INSULIN        = WEIGHT_W'(-1);
    localparam logic signed [WEIGHT_W-1:0] W_BMI            = WEIGHT_W'(22);
    localparam logic signed [WEIGHT_W-1:0] W_AGE            = WEIGHT_W'(4);

    localparam logic signed [ACC_W-1:0] BIAS = ACC_W'(-2400);

    // Coefficient lookup by feature index; unused index 7 yields zero.
    function automatic logic signed [WEIGHT_W-1:0] weight_of(input logic [IDX_W-1:0] idx);
        case (feature_e'(idx))
            PREGNANCIES:    weight_of = W_PREGNANCIES;
            GLUCOSE:        weight_of = W_GLUCOSE;
            BLOOD_PRESSURE: weight_of = W_BLOOD_PRESSURE;
            SKIN_THICKNESS: weight_of = W_SKIN_THICKNESS;
            INSULIN:        weight_of = W_INSULIN;
            BMI:            weight_of = W_BMI;
            AGE:            weight_of = W_AGE;
            default:        weight_of = '0;
        endcase
    endfunction

    // Largest coefficient magnitude, used for the overflow bound below.
    function automatic longint max_abs_weight();
        longint m;
        longint w;
        m = 0;
        for (int i = 0; i < int'(N_FEAT); i++) begin
            w = longint'(weight_of(IDX_W'(i)));
            if (w < 0) w = -w;
            if (w > m) m = w;
        end
        return m;
    endfunction

    // Worst-case score magnitude must fit the signed accumulator without saturation.
    localparam longint SCORE_BOUND = max_abs_weight() * longint'(FEAT_MAX) * longint'(N_FEAT)
                                   + ((BIAS < 0) ? -longint'(BIAS) : longint'(BIAS));
    localparam bit SCORE_BOUND_OK = (SCORE_BOUND < (longint'(1) <<< (ACC_W - 1)));

endpackage

// File: rtl/diabetes_weight_rom.sv
// Combinational coefficient table: feature index to signed weight.
module diabetes_weight_rom
    import diabetes_pkg::*;
(
    input  logic        [IDX_W-1:0]    idx,
    output logic signed [WEIGHT_W-1:0] weight_c
);

    // Table lookup from the package coefficients.
    always_comb begin
        weight_c = weight_of(idx);
    end

endmodule

// File: rtl/diabetes_classifier.sv
// Sequential single-multiplier linear classifier producing a score and a BCD outcome digit.
module diabetes_classifier
    import diabetes_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       start,
    input  logic [N_FEAT*FEAT_W-1:0]   features,
    output logic                       busy,
    output logic                       done,
    output logic signed [ACC_W-1:0]    score,
    output logic [OUTCOME_W-1:0]       outcome
);

    if (!SCORE_BOUND_OK) begin : g_bound_check
        $fatal(1, "diabetes_classifier: coefficients can overflow the accumulator");
    end

    state_e                           state_q, state_d;
    logic [N_FEAT-1:0][FEAT_W-1:0]    feat_q, feat_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic signed [ACC_W-1:0]          acc_q, acc_d;
    logic signed [ACC_W-1:0]          score_q, score_d;
    logic [OUTCOME_W-1:0]             outcome_q, outcome_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic signed [WEIGHT_W-1:0]       weight_c;
    logic signed [FEAT_W:0]           feat_s_c;
    logic signed [PROD_W-1:0]         prod_c;

    diabetes_weight_rom u_weight_rom (
        .idx      (idx_q),
        .weight_c (weight_c)
    );

    // Signed product of the current weight and the zero-extended captured feature.
    always_comb begin
        feat_s_c = {1'b0, feat_q[idx_q]};
        prod_c   = PROD_W'(weight_c) * PROD_W'(feat_s_c);
    end

    // Next-state and datapath control for IDLE -> MAC -> DECIDE.
    always_comb begin
        state_d   = state_q;
        feat_d    = feat_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        score_d   = score_q;
        outcome_d = outcome_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    feat_d  = features;
                    acc_d   = BIAS;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_W'(prod_c);
                if (idx_q == IDX_W'(N_FEAT - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DECIDE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DECIDE: begin
                score_d   = acc_q;
                outcome_d = (acc_q > 0) ? OUTCOME_W'(1) : OUTCOME_W'(0);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; the operator clear key aborts exactly like reset.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q   <= ST_IDLE;
            feat_q    <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            score_q   <= '0;
            outcome_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            feat_q    <= feat_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            score_q   <= score_d;
            outcome_q <= outcome_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign score   = score_q;
    assign outcome = outcome_q;

endmodule

// File: tb/tb_diabetes_classifier.sv
// Directed bench for diabetes_classifier: latency, scores, capture, back-to-back and abort.
module tb_diabetes_classifier;

    localparam int unsigned FW = 14;
    localparam int unsigned NF = 7;

    logic                 clock;
    logic                 reset;
    logic                 clear;
    logic                 start;
    logic [NF*FW-1:0]     features;
    logic                 busy;
    logic                 done;
    logic signed [31:0]   score;
    logic [3:0]           outcome;

    int checks;
    int failures;

    diabetes_classifier dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .start    (start),
        .features (features),
        .busy     (busy),
        .done     (done),
        .score    (score),
        .outcome  (outcome)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [NF*FW-1:0] pack(input int p, input int g, input int bp, input int st,
                                              input int ins, input int bmi, input int age);
        logic [NF*FW-1:0] f;
        f = '0;
        f[0*FW +: FW] = FW'(p);
        f[1*FW +: FW] = FW'(g);
        f[2*FW +: FW] = FW'(bp);
        f[3*FW +: FW] = FW'(st);
        f[4*FW +: FW] = FW'(ins);
        f[5*FW +: FW] = FW'(bmi);
        f[6*FW +: FW] = FW'(age);
        return f;
    endfunction

    // Pulse start with f, swap to f_after right after the start edge, wait for done (bounded).
    // Returns with the bench sitting on the falling edge where done was seen.
    task automatic run_op(input logic [NF*FW-1:0] f, input logic [NF*FW-1:0] f_after,
                          output int lat, output int busy_cnt);
        @(negedge clock);
        features = f;
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start    = 1'b0;
        features = f_after;
        busy_cnt = busy ? 1 : 0;
        lat      = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; start = 1'b0; features = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (score !== 32'sd0 || outcome !== 4'd0) begin
            failures++;
            $display("FAIL reset_result: score=%0d outcome=%0d expected 0 0", score, outcome);
        end
    endtask

    task automatic test_zero_features();
        int lat, bc;
        run_op(pack(0, 0, 0, 0, 0, 0, 0), pack(0, 0, 0, 0, 0, 0, 0), lat, bc);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL zero_latency: got %0d expected 8", lat);
        end
        checks++;
        if (bc !== 8) begin
            failures++;
            $display("FAIL zero_busy_cycles: got %0d expected 8", bc);
        end
        checks++;
        if (score !== -32'sd2400 || outcome !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_score: score=%0d outcome=%0d busy=%b expected -2400 0 0", score, outcome, busy);
        end
    endtask

    task automatic test_positive();
        int lat, bc;
        run_op(pack(5, 200, 0, 0, 0, 40, 50), pack(5, 200, 0, 0, 0, 40, 50), lat, bc);
        checks++;
        if (lat !== 8 || score !== 32'sd640 || outcome !== 4'd1) begin
            failures++;
            $display("FAIL positive_score: lat=%0d score=%0d outcome=%0d expected 8 640 1", lat, score, outcome);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || score !== 32'sd640) begin
            failures++;
            $display("FAIL done_single_cycle: done=%b score=%0d expected 0 640", done, score);
        end
    endtask

    task automatic test_capture();
        int lat, bc;
        run_op(pack(0, 0, 0, 0, 9999, 0, 0), pack(9999, 9999, 9999, 9999, 0, 9999, 9999), lat, bc);
        checks++;
        if (lat !== 8 || score !== -32'sd12399 || outcome !== 4'd0) begin
            failures++;
            $display("FAIL capture_insulin: lat=%0d score=%0d outcome=%0d expected 8 -12399 0", lat, score, outcome);
        end
        run_op(pack(0, 0, 9999, 0, 0, 0, 0), pack(0, 0, 9999, 0, 0, 0, 0), lat, bc);
        checks++;
        if (lat !== 8 || score !== -32'sd32397 || outcome !== 4'd0) begin
            failures++;
            $display("FAIL negative_bp: lat=%0d score=%0d outcome=%0d expected 8 -32397 0", lat, score, outcome);
        end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        n_done = 0;
        @(negedge clock);
        features = pack(5, 200, 0, 0, 0, 40, 50);
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 1) begin
            failures++;
            $display("FAIL start_while_busy: done pulses=%0d expected 1", n_done);
        end
    endtask

    task automatic test_back_to_back();
        int n_done, last_k, bad_gap, bad_score;
        n_done = 0; last_k = 0; bad_gap = 0; bad_score = 0;
        @(negedge clock);
        features = pack(5, 200, 0, 0, 0, 40, 50);
        start    = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                if (n_done == 0 && k != 8) bad_gap++;
                if (n_done > 0 && (k - last_k) != 9) bad_gap++;
                if (score !== 32'sd640) bad_score++;
                n_done++;
                last_k = k;
            end
        end
        start = 1'b0;
        repeat (15) @(posedge clock);
        checks++;
        if (n_done !== 4) begin
            failures++;
            $display("FAIL b2b_count: done pulses=%0d expected 4", n_done);
        end
        checks++;
        if (bad_gap !== 0) begin
            failures++;
            $display("FAIL b2b_spacing: bad gaps=%0d expected 0", bad_gap);
        end
        checks++;
        if (bad_score !== 0) begin
            failures++;
            $display("FAIL b2b_score: bad scores=%0d expected 0", bad_score);
        end
    endtask

    task automatic test_clear();
        int n_done, lat, bc;
        n_done = 0;
        @(negedge clock);
        features = pack(9, 150, 70, 20, 80, 33, 40);
        start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 4) begin
                clear = 1'b1;
                start = 1'b1;
            end
        end
        clear = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || score !== 32'sd0 || outcome !== 4'd0) begin
            failures++;
            $display("FAIL clear_abort: busy=%b done=%b score=%0d outcome=%0d expected 0 0 0 0",
                     busy, done, score, outcome);
        end
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            failures++;
            $display("FAIL clear_no_done: done pulses=%0d expected 0", n_done);
        end
        run_op(pack(0, 300, 0, 0, 0, 30, 25), pack(0, 300, 0, 0, 0, 30, 25), lat, bc);
        checks++;
        if (lat !== 8 || score !== 32'sd1060 || outcome !== 4'd1) begin
            failures++;
            $display("FAIL after_clear: lat=%0d score=%0d outcome=%0d expected 8 1060 1", lat, score, outcome);
        end
    endtask

    task automatic test_max_features();
        int lat, bc;
        run_op(pack(9999, 9999, 9999, 9999, 9999, 9999, 9999),
               pack(9999, 9999, 9999, 9999, 9999, 9999, 9999), lat, bc);
        checks++;
        if (lat !== 8 || score !== 32'sd627537 || outcome !== 4'd1) begin
            failures++;
            $display("FAIL max_features: lat=%0d score=%0d outcome=%0d expected 8 627537 1", lat, score, outcome);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero_features();
        test_positive();
        test_capture();
        test_start_while_busy();
        test_back_to_back();
        test_clear();
        test_max_features();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/diabetes_classifier.md
Name: diabetes_classifier

Overview:
- Downstream stage of the keypad entry/display block. Consumes the seven decimal feature values the operator entered (Pregnancies, Glucose, BloodPressure, SkinThickness, Insulin, BMI, Age; each 0..9999).
- Computes a fixed integer linear score `BIAS + sum(W[i]*x[i])` with a sequential single-multiplier MAC. Returns the Outcome digit (0/1) for the display block's Outcome state.
- Start/done handshake. Features are captured on start, so the entry block may change them afterwards.

Parameters:
- FEAT_W, 14, width of one feature value (holds 0..9999)
- WEIGHT_W, 16, signed weight width
- ACC_W, 32, signed accumulator/score width
- N_FEAT, 7, number of features, fixed by the package

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- clear  in  1  synchronous abort from the operator clear key; same effect as reset on this block's state
- start  in  1  request classification; sampled only in IDLE
- features  in  N_FEAT*FEAT_W  packed values, field i = bits [i*FEAT_W +: FEAT_W], index per package feature enum
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse when score/outcome update
- score  out  ACC_W  signed final score, held until next done/clear/reset
- outcome  out  4  BCD digit: 1 if score > 0, else 0; drives the display directly

Behaviour:
- Reset or clear: state=IDLE, busy=0, done=0, score=0, outcome=0, idx=0, acc=0. Clear has priority over start. Clear mid-computation aborts with no done pulse.
- States: IDLE -> MAC -> DECIDE -> IDLE.
- IDLE:
  - start=1 at edge E0: capture all features into internal regs, acc<=BIAS, idx<=0, busy<=1, state<=MAC.
  - start=0: hold.
- MAC, edges E1..E7:
  - acc <= acc + sext(W[idx]) * zext(x[idx]).
  - Features are unsigned and zero-extended with one sign bit; products are signed.
  - idx increments. After idx=6 is accumulated, state<=DECIDE.
- DECIDE, edge E8:
  - score<=acc, outcome<=(acc>0)?1:0, done<=1, busy<=0, state<=IDLE.
- Edge E9: done<=0.
- Latency: done visible 8 clocks after the start-sampling edge. Throughput: one result per 9 clocks. start may be high on E9 and is accepted there (back-to-back).
- start while busy: ignored, not queued.
- start held high: a new computation is accepted each time the block returns to IDLE.
- Width rule: max |W|*9999*7 + |BIAS| < 2^31, so no overflow and no saturation. The package asserts this bound.
- Inputs at or above 10000 (invalid BCD sums): computed as-is; no range check.

Decomposition:
- Package diabetes_pkg:
  - feature index enum: PREGNANCIES=0, GLUCOSE=1, BLOOD_PRESSURE=2, SKIN_THICKNESS=3, INSULIN=4, BMI=5, AGE=6
  - FSM state enum
  - weight constants: W = {32, 9, -3, 0, -1, 22, 4} in index order
  - BIAS = -2400
  - widths
- Sub-module diabetes_weight_rom: combinational idx -> signed WEIGHT_W weight from the package constants. Keeps the coefficients swappable without touching the FSM.

Test Plan:
- Reset, then all features 0, pulse start -> busy for 8 clocks, done 8 clocks after start, score=-2400, outcome=0.
- Preg=5, Glucose=200, BMI=40, Age=50, others 0 -> score=640, outcome=1; done a single cycle wide.
- Insulin=9999, others 0 -> score=-12399, outcome=0. Change features after the start edge -> result unchanged (capture check).
- Start on cycle 3 of a busy run -> ignored, exactly one done. Start held continuously -> done every 9 clocks with identical score.
- Clear asserted at MAC idx=4 with start also high -> no done, busy=0, score=0, outcome=0 next cycle. A subsequent start yields a correct full result.
- Features all 9999 -> score=9999*63-2400=627537, outcome=1 (worst-case positive width check).
